// File: rtl/mux41_tree_reg.sv
// Registered 4:1 multiplexer built from three 2:1 cells in two levels
// (s[0] at level 1, s[1] at level 2), with an optional inter-level register.
module mux41_tree_reg #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned PIPE  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  input  logic [1:0]       s,
  input  logic             in_valid,
  output logic [WIDTH-1:0] y,
  output logic             out_valid
);

  function automatic logic [WIDTH-1:0] mux2(
    input logic             sel,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    return sel ? b : a;
  endfunction

  logic [WIDTH-1:0] m0, m1, d;
  logic [WIDTH-1:0] l2_m0, l2_m1;
  logic             l2_sel, l2_valid;

  always_comb begin
    m0 = mux2(s[0], i0, i1);
    m1 = mux2(s[0], i2, i3);
  end

  generate
    if (PIPE != 0) begin : g_pipe
      // s[1] and valid travel with the level-1 results so level 2 stays aligned
      logic [WIDTH-1:0] m0_q, m1_q;
      logic             s1_q, valid_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          m0_q    <= '0;
          m1_q    <= '0;
          s1_q    <= 1'b0;
          valid_q <= 1'b0;
        end else begin
          m0_q    <= m0;
          m1_q    <= m1;
          s1_q    <= s[1];
          valid_q <= in_valid;
        end
      end

      always_comb begin
        l2_m0    = m0_q;
        l2_m1    = m1_q;
        l2_sel   = s1_q;
        l2_valid = valid_q;
      end
    end else begin : g_comb
      always_comb begin
        l2_m0    = m0;
        l2_m1    = m1;
        l2_sel   = s[1];
        l2_valid = in_valid;
      end
    end
  endgenerate

  always_comb d = mux2(l2_sel, l2_m0, l2_m1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y         <= '0;
      out_valid <= 1'b0;
    end else if (l2_valid) begin
      y         <= d;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux41_tree_reg.sv
// Directed bench for mux41_tree_reg: one PIPE=0 and one PIPE=1 instance
// (WIDTH=8) driven with identical stimulus; the PIPE=1 copy lags by one cycle.
module tb_mux41_tree_reg;

  logic       clk;
  logic       rst_n;
  logic [7:0] i0, i1, i2, i3;
  logic [1:0] s;
  logic       in_valid;
  logic [7:0] y_p0, y_p1;
  logic       ov_p0, ov_p1;

  int checks = 0;
  int errors = 0;

  logic [7:0] prev_y;
  logic       prev_v;
  logic [7:0] last_y;

  mux41_tree_reg #(.WIDTH(8), .PIPE(0)) dut_p0 (
    .clk(clk), .rst_n(rst_n), .i0(i0), .i1(i1), .i2(i2), .i3(i3),
    .s(s), .in_valid(in_valid), .y(y_p0), .out_valid(ov_p0)
  );

  mux41_tree_reg #(.WIDTH(8), .PIPE(1)) dut_p1 (
    .clk(clk), .rst_n(rst_n), .i0(i0), .i1(i1), .i2(i2), .i3(i3),
    .s(s), .in_valid(in_valid), .y(y_p1), .out_valid(ov_p1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, then check PIPE=0 against ey/ev and PIPE=1 against
  // the expectation given for the previous cycle.
  task automatic step(input logic [7:0] a0, input logic [7:0] a1,
                      input logic [7:0] a2, input logic [7:0] a3,
                      input logic [1:0] sel, input logic v,
                      input logic [7:0] ey, input logic ev, input string tag);
    i0 = a0; i1 = a1; i2 = a2; i3 = a3; s = sel; in_valid = v;
    @(posedge clk);
    #1;
    chk({tag, " p0 y"}, y_p0, ey);
    chk({tag, " p0 out_valid"}, {7'd0, ov_p0}, {7'd0, ev});
    chk({tag, " p1 y"}, y_p1, prev_y);
    chk({tag, " p1 out_valid"}, {7'd0, ov_p1}, {7'd0, prev_v});
    prev_y = ey;
    prev_v = ev;
  endtask

  initial begin
    logic [3:0] p;
    logic [7:0] e;
    rst_n = 1'b0;
    i0 = '0; i1 = '0; i2 = '0; i3 = '0; s = '0; in_valid = 1'b0;
    prev_y = '0; prev_v = 1'b0; last_y = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset p0 y", y_p0, 8'h00);
    chk("reset p0 out_valid", {7'd0, ov_p0}, 8'h00);
    chk("reset p1 y", y_p1, 8'h00);
    chk("reset p1 out_valid", {7'd0, ov_p1}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // constant data 0,1,0,1 with s stepping 0..3
    step(8'h00, 8'h01, 8'h00, 8'h01, 2'd0, 1'b1, 8'h00, 1'b1, "walk s0");
    step(8'h00, 8'h01, 8'h00, 8'h01, 2'd1, 1'b1, 8'h01, 1'b1, "walk s1");
    step(8'h00, 8'h01, 8'h00, 8'h01, 2'd2, 1'b1, 8'h00, 1'b1, "walk s2");
    step(8'h00, 8'h01, 8'h00, 8'h01, 2'd3, 1'b1, 8'h01, 1'b1, "walk s3");

    // back-to-back byte selection
    step(8'hA0, 8'hB1, 8'hC2, 8'hD3, 2'd3, 1'b1, 8'hD3, 1'b1, "byte s3");
    step(8'hA0, 8'hB1, 8'hC2, 8'hD3, 2'd2, 1'b1, 8'hC2, 1'b1, "byte s2");
    step(8'hA0, 8'hB1, 8'hC2, 8'hD3, 2'd1, 1'b1, 8'hB1, 1'b1, "byte s1");
    step(8'hA0, 8'hB1, 8'hC2, 8'hD3, 2'd0, 1'b1, 8'hA0, 1'b1, "byte s0");

    // simultaneous data and select change
    step(8'h11, 8'h22, 8'h33, 8'h44, 2'd2, 1'b1, 8'h33, 1'b1, "datasel chg");

    // valid toggling: y holds through the invalid cycle despite new data
    step(8'h00, 8'h01, 8'h00, 8'h00, 2'd1, 1'b1, 8'h01, 1'b1, "valid 1a");
    step(8'hEE, 8'hFF, 8'hEE, 8'hEE, 2'd1, 1'b0, 8'h01, 1'b0, "valid 0");
    step(8'h00, 8'h01, 8'h00, 8'h00, 2'd1, 1'b1, 8'h01, 1'b1, "valid 1b");
    step(8'h00, 8'h01, 8'h00, 8'h00, 2'd1, 1'b1, 8'h01, 1'b1, "valid 1c");

    // asynchronous reset between edges while y = 1
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst p0 y", y_p0, 8'h00);
    chk("async rst p0 out_valid", {7'd0, ov_p0}, 8'h00);
    chk("async rst p1 y", y_p1, 8'h00);
    chk("async rst p1 out_valid", {7'd0, ov_p1}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    prev_y = '0;
    prev_v = 1'b0;
    step(8'h00, 8'h00, 8'h00, 8'h01, 2'd3, 1'b1, 8'h01, 1'b1, "post rst a");
    step(8'h00, 8'h00, 8'h00, 8'h01, 2'd3, 1'b0, 8'h01, 1'b0, "post rst b");

    // exhaustive: every select against every 4-bit input pattern
    for (int sel = 0; sel < 4; sel++) begin
      for (int pat = 0; pat < 16; pat++) begin
        p = pat[3:0];
        e = {8{p[sel]}};
        step({8{p[0]}}, {8{p[1]}}, {8{p[2]}}, {8{p[3]}}, sel[1:0], 1'b1,
             e, 1'b1, $sformatf("exh s%0d p%0h", sel, pat));
        last_y = e;
      end
    end
    step(8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 1'b0, last_y, 1'b0, "exh flush");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux41_tree_reg.md
# mux41_tree_reg

Registered 4:1 multiplexer built as a two-level tree of three 2:1 multiplexer cells. Level 1 resolves `s[0]` and level 2 resolves `s[1]`. An optional pipeline register sits between the levels, and a final output register holds the result. It is the reference selector element used by datapath steering logic and as a structural example of mux composition.

## Interface
Parameters:
- `WIDTH`, default 1: data width of each input and of `y`.
- `PIPE`, default 0: 0 = no inter-level register; 1 = register the level-1 results and `s[1]` before level 2.

Ports:
- `clk`, input, 1: sole clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low. Asserting it clears all registers immediately; release is synchronous to `clk` by design of the surrounding system.
- `i0`, `i1`, `i2`, `i3`, input, WIDTH each: data inputs.
- `s`, input, 2: select; `s = k` selects `ik`.
- `in_valid`, input, 1: qualifies `i0..i3` and `s` in the current cycle.
- `y`, output, WIDTH: registered selected data.
- `out_valid`, output, 1: `y` holds a result produced from a valid input.

## Operation
- Structure: exactly three 2:1 cells, each `o = sel ? b : a`.
  - Level 1: `m0 = s[0] ? i1 : i0`; `m1 = s[0] ? i3 : i2`.
  - Level 2: `d = s[1] ? m1 : m0`.
- Resulting function: s=00 → i0, 01 → i1, 10 → i2, 11 → i3, for every bit of WIDTH independently.
- PIPE=1: `m0`, `m1`, `s[1]` and `in_valid` are captured together in stage-1 registers. Level 2 uses only the registered copies, so select and data stay aligned.
- Output register:
  - On a cycle with the relevant valid set, `y <= d` and `out_valid <= 1`.
  - On a cycle with valid clear, `y` holds its previous value and `out_valid <= 0`.
- No X-propagation special handling. Select is always 2 bits, so every value is legal and there is no default branch beyond the four cases.
- Reset values: `y = 0`, `out_valid = 0`, and all stage-1 registers = 0.

## Timing
- PIPE=0: latency 1 cycle. Inputs sampled at edge N appear on `y` after edge N.
- PIPE=1: latency 2 cycles.
- Throughput: one new selection per cycle in both configurations. There is no backpressure and no stall input.
- Back-to-back select changes:
  - Each cycle's result reflects that cycle's `s` and data only.
  - Consecutive changes with `in_valid` held at 1 produce one output per cycle, in order.
- Reset mid-operation: `rst_n` low clears `y`, `out_valid` and the pipeline immediately, without waiting for a clock. In-flight results are discarded. The first valid output after release arrives after the normal latency.
- Simultaneous data and select change in one cycle: the output is the new data through the new select. There is no mixing of old and new values.

## Test plan
- Constant data i0=0, i1=1, i2=0, i3=1, `in_valid`=1; step `s` through 0, 1, 2, 3, one per 10 ns cycle (PIPE=0) → `y` is 0, 1, 0, 1, each one cycle later, with `out_valid`=1.
- WIDTH=8, i0=8'hA0, i1=8'hB1, i2=8'hC2, i3=8'hD3; `s` = 3, 2, 1, 0 back-to-back:
  - PIPE=0 → `y` is D3, C2, B1, A0 on consecutive cycles.
  - PIPE=1 → same sequence shifted one cycle later.
- `in_valid` toggled 1, 0, 1 with `s`=1 and i1=1 → `out_valid` follows 1, 0, 1 at the configured latency; `y` holds 1 through the invalid cycle.
- Assert `rst_n`=0 between clock edges while `y`=1 → `y`=0 and `out_valid`=0 before the next edge. After release with `s`=3, i3=1, `in_valid`=1 → `y`=1 after the configured latency.
- Exhaustive (WIDTH=1, PIPE=0 and PIPE=1): all 4 select values × all 16 input patterns, compared against a behavioural `ik` model at the configured latency → zero mismatches.
